// File: rtl/mixer_pkg.sv
// ----------------------------------------------------------------------------
// mixer_pkg: default voice/oscillator geometry and sequencer state encoding.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mixer_pkg;

    localparam int VOICES     = 8;
    localparam int V_OSC      = 4;
    localparam int O_ENVS     = 2;
    localparam int V_WIDTH    = 3;
    localparam int O_WIDTH    = 2;
    localparam int OE_WIDTH   = 1;
    localparam int E_WIDTH    = O_WIDTH + OE_WIDTH;
    localparam int SLOT_WIDTH = V_WIDTH + E_WIDTH;
    localparam int TOTAL      = VOICES * V_OSC * O_ENVS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PRESENT = 2'd3
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/mixer_slot_counter.sv
// ----------------------------------------------------------------------------
// mixer_slot_counter: {voice, osc, env} slot index that saturates at the last slot.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mixer_slot_counter #(
    parameter int SLOT_COUNT = 64,
    parameter int WIDTH      = 6
) (
    input  logic             sCLK_XVXENVS,
    input  logic             iRST_N,
    input  logic             start,
    input  logic             active,
    output logic [WIDTH-1:0] xxxx,
    output logic             n_xxxx_zero,
    output logic             last_slot
);

    import mixer_pkg::*;

    localparam logic [WIDTH-1:0] LAST = WIDTH'(SLOT_COUNT - 1);

    assign last_slot   = active && (xxxx == LAST);
    assign n_xxxx_zero = active && (xxxx == '0);

    // Holding at LAST keeps the index in range even if active lingers.
    always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
        if (!iRST_N) begin
            xxxx <= '0;
        end else if (start) begin
            xxxx <= '0;
        end else if (active && (xxxx != LAST)) begin
            xxxx <= xxxx + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mixer_sequencer.sv
// ----------------------------------------------------------------------------
// mixer_sequencer: per-frame slot scan, pipeline drain and sample presentation.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mixer_sequencer #(
    parameter int VOICES    = mixer_pkg::VOICES,
    parameter int V_OSC     = mixer_pkg::V_OSC,
    parameter int O_ENVS    = mixer_pkg::O_ENVS,
    parameter int V_WIDTH   = mixer_pkg::V_WIDTH,
    parameter int O_WIDTH   = mixer_pkg::O_WIDTH,
    parameter int OE_WIDTH  = mixer_pkg::OE_WIDTH,
    parameter int DRAIN_CYC = V_OSC + 4
) (
    input  logic                                sCLK_XVXENVS,
    input  logic                                iRST_N,
    input  logic                                frame_start,
    input  logic signed [15:0]                  lsound_in,
    input  logic signed [15:0]                  rsound_in,
    input  logic                                out_ready,
    input  logic                                clr_overrun,
    output logic [V_WIDTH+O_WIDTH+OE_WIDTH-1:0] xxxx,
    output logic                                n_xxxx_zero,
    output logic                                busy,
    output logic                                sample_valid,
    output logic signed [15:0]                  lsample,
    output logic signed [15:0]                  rsample,
    output logic                                overrun
);

    import mixer_pkg::*;

    localparam int E_W    = O_WIDTH + OE_WIDTH;
    localparam int SLOT_W = V_WIDTH + E_W;
    localparam int SLOTS  = VOICES * V_OSC * O_ENVS;
    localparam int DCW    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

    seq_state_t     state;
    seq_state_t     state_next;
    logic           scan_start;
    logic           scan_last;
    logic           drain_last;
    logic [DCW-1:0] drain_cnt;

    mixer_slot_counter #(
        .SLOT_COUNT (SLOTS),
        .WIDTH      (SLOT_W)
    ) u_slot_counter (
        .sCLK_XVXENVS (sCLK_XVXENVS),
        .iRST_N       (iRST_N),
        .start        (scan_start),
        .active       (state == ST_SCAN),
        .xxxx         (xxxx),
        .n_xxxx_zero  (n_xxxx_zero),
        .last_slot    (scan_last)
    );

    assign drain_last = (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);

    always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        scan_start   = 1'b0;
        busy         = 1'b0;
        sample_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    state_next = ST_SCAN;
                    scan_start = 1'b1;
                end
            end
            ST_SCAN: begin
                busy = 1'b1;
                if (scan_last) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drain_last) state_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                sample_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
        if (!iRST_N) begin
            drain_cnt <= '0;
        end else if (state != ST_DRAIN) begin
            drain_cnt <= '0;
        end else if (!drain_last) begin
            drain_cnt <= drain_cnt + DCW'(1);
        end
    end

    // The mixer output is only meaningful once the pipeline has fully drained.
    always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
        if (!iRST_N) begin
            lsample <= '0;
            rsample <= '0;
        end else if (drain_last) begin
            lsample <= lsound_in;
            rsample <= rsound_in;
        end
    end

    // A tick outside IDLE means the previous frame overran; set beats clear.
    always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
        if (!iRST_N) begin
            overrun <= 1'b0;
        end else if (frame_start && (state != ST_IDLE)) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mixer_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mixer_sequencer: scoreboard bench for the default and a reduced geometry.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mixer_sequencer;

    localparam int SLOTS   = 64;
    localparam int DRAIN   = 8;
    localparam int SLOTS_S = 8;
    localparam int DRAIN_S = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               frame_start, out_ready, clr_overrun;
    logic               frame_start_s, out_ready_s;
    logic signed [15:0] lsound_in, rsound_in;

    logic [5:0]         xxxx;
    logic               nz, busy, sample_valid, overrun;
    logic signed [15:0] lsample, rsample;

    logic [2:0]         xxxx_s;
    logic               nz_s, busy_s, sv_s, ov_s;
    logic signed [15:0] lsample_s, rsample_s;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    mixer_sequencer dut (
        .sCLK_XVXENVS (clk),
        .iRST_N       (rst_n),
        .frame_start  (frame_start),
        .lsound_in    (lsound_in),
        .rsound_in    (rsound_in),
        .out_ready    (out_ready),
        .clr_overrun  (clr_overrun),
        .xxxx         (xxxx),
        .n_xxxx_zero  (nz),
        .busy         (busy),
        .sample_valid (sample_valid),
        .lsample      (lsample),
        .rsample      (rsample),
        .overrun      (overrun)
    );

    mixer_sequencer #(
        .VOICES  (2),
        .V_OSC   (2),
        .V_WIDTH (1),
        .O_WIDTH (1)
    ) dut_small (
        .sCLK_XVXENVS (clk),
        .iRST_N       (rst_n),
        .frame_start  (frame_start_s),
        .lsound_in    (lsound_in),
        .rsound_in    (rsound_in),
        .out_ready    (out_ready_s),
        .clr_overrun  (clr_overrun),
        .xxxx         (xxxx_s),
        .n_xxxx_zero  (nz_s),
        .busy         (busy_s),
        .sample_valid (sv_s),
        .lsample      (lsample_s),
        .rsample      (rsample_s),
        .overrun      (ov_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sound();
        lsound_in = 16'($urandom);
        rsound_in = 16'($urandom);
    endtask

    task automatic pop_expected(output logic [31:0] e);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    // Cycle 0 carries frame_start; cycle k is k clocks later.
    task automatic run_frame(input int stall, input int ovr_at, input bit fs_on_hs);
        logic [31:0] e;
        frame_start = 1'b1;
        drive_sound();
        tick();
        frame_start = 1'b0;
        for (int k = 1; k <= SLOTS + DRAIN; k++) begin
            check("xxxx", 32'(xxxx), (k <= SLOTS) ? 32'(k - 1) : 32'(SLOTS - 1));
            check("busy", 32'(busy), 32'd1);
            check("n_xxxx_zero", 32'(nz), 32'(k == 1));
            check("valid_low", 32'(sample_valid), 32'd0);
            if (ovr_at > 0 && k == ovr_at + 1) check("overrun_set", 32'(overrun), 32'd1);
            frame_start = (ovr_at > 0) && (k == ovr_at);
            clr_overrun = (ovr_at > 0) && (k == ovr_at);
            drive_sound();
            if (k == SLOTS + DRAIN) exp_q.push_back({lsound_in, rsound_in});
            tick();
        end
        frame_start = 1'b0;
        clr_overrun = 1'b0;
        check("valid_latency", 32'(sample_valid), 32'd1);
        check("busy_present", 32'(busy), 32'd0);
        check("xxxx_hold", 32'(xxxx), 32'(SLOTS - 1));
        pop_expected(e);
        if (stall > 0) out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            check("sample_stable", {lsample, rsample}, e);
            check("valid_stall", 32'(sample_valid), 32'd1);
            drive_sound();
            tick();
        end
        check("sample", {lsample, rsample}, e);
        out_ready   = 1'b1;
        frame_start = fs_on_hs;
        tick();
        frame_start = 1'b0;
        check("valid_drop", 32'(sample_valid), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("nz_idle", 32'(nz), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] e;
        int cnt;
        rst_n = 1'b0;
        frame_start = 1'b0; out_ready = 1'b0; clr_overrun = 1'b0;
        frame_start_s = 1'b0; out_ready_s = 1'b0;
        lsound_in = '0; rsound_in = '0;
        tick();
        tick();
        check("rst_xxxx", 32'(xxxx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_nz", 32'(nz), 32'd0);
        check("rst_sample", {lsample, rsample}, 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        tick();

        // Plain frame; out_ready held high through the scan has no effect.
        out_ready = 1'b1;
        run_frame(0, 0, 0);

        // Backpressure plus an overrun tick during scan, with a coincident clear.
        out_ready = 1'b0;
        run_frame(20, 10, 0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("overrun_clear", 32'(overrun), 32'd0);

        // frame_start coincident with the handshake: no new scan, overrun set.
        out_ready = 1'b0;
        run_frame(3, 0, 1);
        check("hs_overrun", 32'(overrun), 32'd1);
        out_ready = 1'b0;
        tick();
        check("hs_no_scan", 32'(busy), 32'd0);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("hs_overrun_clear", 32'(overrun), 32'd0);

        // Reset mid-scan at slot 30, with overrun set beforehand.
        frame_start = 1'b1;
        tick();
        for (int k = 1; k <= 31; k++) begin
            frame_start = (k == 5);
            if (k < 31) tick();
        end
        frame_start = 1'b0;
        check("pre_rst_xxxx", 32'(xxxx), 32'd30);
        check("pre_rst_overrun", 32'(overrun), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_xxxx", 32'(xxxx), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_nz", 32'(nz), 32'd0);
        check("async_valid", 32'(sample_valid), 32'd0);
        check("async_sample", {lsample, rsample}, 32'd0);
        check("async_overrun", 32'(overrun), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_idle", 32'(busy), 32'd0);
            check("post_rst_valid", 32'(sample_valid), 32'd0);
        end
        run_frame(2, 0, 0);

        // Reduced geometry: 8 slots, 6 drain cycles.
        frame_start_s = 1'b1;
        drive_sound();
        tick();
        frame_start_s = 1'b0;
        cnt = 1;
        check("s_first_xxxx", 32'(xxxx_s), 32'd0);
        check("s_first_nz", 32'(nz_s), 32'd1);
        while (!sv_s && cnt < 50) begin
            drive_sound();
            if (cnt == SLOTS_S + DRAIN_S) exp_q.push_back({lsound_in, rsound_in});
            tick();
            cnt++;
        end
        check("s_latency", 32'(cnt), 32'(SLOTS_S + DRAIN_S + 1));
        check("s_xxxx_hold", 32'(xxxx_s), 32'(SLOTS_S - 1));
        pop_expected(e);
        check("s_sample", {lsample_s, rsample_s}, e);
        out_ready_s = 1'b1;
        tick();
        out_ready_s = 1'b0;
        check("s_valid_drop", 32'(sv_s), 32'd0);
        check("s_overrun", 32'(ov_s), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mixer_sequencer.md
MIXER_SEQUENCER -- requirements
Module: mixer_sequencer

Interface
REQ-001 Parameter VOICES, default 8, voice count.
REQ-002 Parameter V_OSC, default 4, oscillators per voice.
REQ-003 Parameter O_ENVS, default 2, envelopes per oscillator.
REQ-004 Parameter V_WIDTH, default 3; O_WIDTH, default 2; OE_WIDTH, default 1; E_WIDTH = O_WIDTH+OE_WIDTH.
REQ-005 Parameter DRAIN_CYC, default V_OSC+4, number of pipeline flush cycles after the scan.
REQ-006 Port sCLK_XVXENVS, input, 1, clock; all state updates on the rising edge.
REQ-007 Port iRST_N, input, 1, reset; asynchronous, active-low.
REQ-008 Port frame_start, input, 1, one-cycle sample-rate tick.
REQ-009 Port lsound_in / rsound_in, input, 16 signed each, mixer sample outputs.
REQ-010 Port out_ready, input, 1, sink accepts the sample.
REQ-011 Port clr_overrun, input, 1, clears the overrun flag.
REQ-012 Port xxxx, output, V_WIDTH+E_WIDTH, slot index {voice, osc, env}.
REQ-013 Port n_xxxx_zero, output, 1, high while xxxx==0 in SCAN.
REQ-014 Port busy, output, 1, high in SCAN or DRAIN.
REQ-015 Port sample_valid, output, 1; lsample / rsample, output, 16 signed each.
REQ-016 Port overrun, output, 1, sticky flag.

Function
REQ-017 The FSM SHALL have states IDLE, SCAN, DRAIN and PRESENT.
REQ-018 IDLE: frame_start=1 SHALL move to SCAN on the next cycle, with xxxx=0 on the first SCAN cycle.
REQ-019 SCAN SHALL increment xxxx by 1 each cycle, from 0 to TOTAL-1, where TOTAL=VOICES*V_OSC*O_ENVS (64 by default).
REQ-020 At xxxx==TOTAL-1 in SCAN, the FSM SHALL move to DRAIN and xxxx SHALL hold TOTAL-1.
REQ-021 DRAIN SHALL last exactly DRAIN_CYC cycles, counted by a drain counter.
REQ-022 On the last DRAIN cycle, the block SHALL register lsound_in/rsound_in into lsample/rsample, and the FSM SHALL go to PRESENT with sample_valid=1 on the next cycle.
REQ-023 Latency: frame_start at cycle T gives xxxx=0 at T+1, last scan slot at T+TOTAL, and sample_valid=1 at T+TOTAL+DRAIN_CYC+1 (T+73 by default).
REQ-024 PRESENT: sample_valid, lsample and rsample SHALL hold stable until sample_valid&&out_ready; the FSM SHALL then go to IDLE and sample_valid SHALL go to 0 the following cycle.
REQ-025 frame_start arriving in any state other than IDLE SHALL be ignored and SHALL set overrun=1, including when it coincides with the out_ready handshake.
REQ-026 clr_overrun SHALL clear overrun the next cycle; if it coincides with a setting event, the set wins.
REQ-027 n_xxxx_zero SHALL be 0 outside SCAN.
REQ-028 Outside SCAN, xxxx SHALL hold its last value.
REQ-029 xxxx SHALL never exceed TOTAL-1; no wrap-around occurs within a frame.
REQ-030 out_ready outside PRESENT SHALL have no effect.

Reset
REQ-031 Reset assertion SHALL force state=IDLE, xxxx=0, drain counter=0, n_xxxx_zero=0, busy=0, sample_valid=0, lsample=0, rsample=0 and overrun=0.
REQ-032 Reset asserted mid-SCAN or mid-DRAIN SHALL abandon the frame with no sample produced; the first frame_start after release starts a fresh scan.

Structure
REQ-033 VOICES, V_OSC, O_ENVS, the width constants, TOTAL and the state enum SHALL reside in package mixer_pkg.
REQ-034 The slot counter (xxxx, n_xxxx_zero, terminal-count flag) SHALL be the single sub-module mixer_slot_counter; the FSM, drain counter and output registers SHALL stay in mixer_sequencer.

Verification
REQ-035 Single frame: frame_start at T, out_ready=1 -> xxxx steps 0..63 over T+1..T+64; n_xxxx_zero=1 only at T+1; busy=1 over T+1..T+72; sample_valid=1 at T+73; lsample equals lsound_in sampled at T+72.
REQ-036 Backpressure: out_ready=0 for 20 cycles after sample_valid rises -> lsample/rsample stable for those 20 cycles; raising out_ready drops sample_valid one cycle later.
REQ-037 Overrun: frame_start at T+10 during SCAN -> overrun=1 at T+11; the scan continues unchanged; clr_overrun then clears overrun.
REQ-038 Simultaneous events: frame_start together with the out_ready handshake -> state returns to IDLE, overrun=1, no new scan starts.
REQ-039 Reset at xxxx=30 -> all outputs take reset values immediately; after release, one frame_start produces one complete 64-slot scan.
REQ-040 Parameter sweep: VOICES=2, V_OSC=2 -> TOTAL=8 and sample_valid rises at T+15.
